imm_encoder: RTL and testbench

- Inverse of the datapath immediate extender: packs a 32-bit immediate into the I/S/B/J immediate fields of an instruction word. Also expands a load-immediate request into a LUI/ADDI sequence.
- Sits between the test-program generator / boot-ROM builder and the instruction memory write port.
- Valid/ready streaming on input and output, one registered output stage, and an FSM for two-word expansion.

---
 rtl/imm_encoder_pkg.sv | 12 +
 rtl/imm_encoder_if.sv | 13 +
 rtl/imm_encoder_field_pack.sv | 20 ++
 rtl/imm_encoder.sv | 75 +++++++
 tb/tb_imm_encoder.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
// riscv_imm_pkg: immediate source coding, LI opcodes, FSM states and range helper
package riscv_imm_pkg;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immsrc_e;
  typedef enum logic {IDLE, SECOND} state_e;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  // true when v[31:msb] are all-equal, i.e. v is a sign extension of v[msb:0]
  function automatic logic fits(input logic [31:0] v, input int unsigned msb);
    return (v >> msb) == 32'd0 || (v >> msb) == (32'hFFFF_FFFF >> msb);
  endfunction
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and instruction-word streams of the immediate encoder
interface imm_encoder_if;
  logic in_valid, in_ready, in_li;
  logic [1:0] in_immsrc;
  logic [31:0] in_imm, in_tmpl;
  logic [4:0] in_rd;
  logic out_valid, out_ready, out_err, out_last;
  logic [31:0] out_instr;
  modport master(output in_valid, in_li, in_immsrc, in_imm, in_tmpl, in_rd, out_ready,
                 input in_ready, out_valid, out_instr, out_err, out_last);
  modport slave(input in_valid, in_li, in_immsrc, in_imm, in_tmpl, in_rd, out_ready,
                output in_ready, out_valid, out_instr, out_err, out_last);
endinterface

// File: rtl/imm_encoder_field_pack.sv
// imm_field_pack: scatters an immediate into the I/S/B/J fields of a template word
module imm_field_pack
  import riscv_imm_pkg::*;
(
  input  logic [31:0] tmpl,
  input  logic [31:0] imm,
  input  immsrc_e     immsrc,
  output logic [31:0] word,
  output logic        err
);
  always_comb begin
    word = immsrc == IMM_I ? {imm[11:0], tmpl[19:0]} :
           immsrc == IMM_S ? {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]} :
           immsrc == IMM_B ? {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]} :
                             {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
    err = immsrc == IMM_I || immsrc == IMM_S ? !fits(imm, 11) :
          immsrc == IMM_B ? imm[0] || !fits(imm, 12) :
                            imm[0] || !fits(imm, 20);
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: registered field packer with LUI/ADDI load-immediate expansion
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter bit LI_EN = 1'b1
) (
  input logic clk,
  input logic reset_n,
  imm_encoder_if.slave bus
);
  state_e state, state_n;
  logic [31:0] instr_q, instr_n, sec_q, sec_n, pack_w, first_w;
  logic valid_q, valid_n, err_q, err_n, last_q, last_n;
  logic pack_err, li, li_one, two, accept;
  logic [11:0] lo;
  logic [19:0] hi;
  imm_field_pack u_pack (
    .tmpl(bus.in_tmpl), .imm(bus.in_imm), .immsrc(immsrc_e'(bus.in_immsrc)),
    .word(pack_w), .err(pack_err)
  );
  assign li = LI_EN && bus.in_li;
  assign lo = bus.in_imm[11:0];
  // ADDI sign-extends lo, so the upper part is rounded up when lo is negative
  assign hi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
  assign li_one = fits(bus.in_imm, 11);
  assign two = li && !li_one && lo != 12'd0;
  assign first_w = !li ? pack_w :
                   li_one ? {lo, 5'd0, F3_ADDI, bus.in_rd, OP_OPIMM} :
                            {hi, bus.in_rd, OP_LUI};
  assign bus.in_ready = state == IDLE && (!valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err = err_q;
  assign bus.out_last = last_q;
  always_comb begin
    state_n = state;
    valid_n = valid_q && !bus.out_ready;
    instr_n = instr_q;
    err_n = err_q;
    last_n = last_q;
    sec_n = sec_q;
    if (accept) begin
      instr_n = first_w;
      err_n = !li && pack_err;
      last_n = !two;
      valid_n = 1'b1;
      sec_n = {lo, bus.in_rd, F3_ADDI, bus.in_rd, OP_OPIMM};
      state_n = two ? SECOND : IDLE;
    end else if (state == SECOND && valid_q && bus.out_ready) begin
      instr_n = sec_q;
      err_n = 1'b0;
      last_n = 1'b1;
      valid_n = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q <= 1'b0;
      last_q <= 1'b0;
      sec_q <= '0;
    end else begin
      state <= state_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      err_q <= err_n;
      last_q <= last_n;
      sec_q <= sec_n;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and random requests checked against an arithmetic reference model
module tb_imm_encoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] obs0, obs1;
  imm_encoder_if bus();
  imm_encoder #(.LI_EN(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: ranges as signed integer intervals, LI split via lo = sext(imm[11:0]), hi = (imm-lo)/4096
  task automatic model(input bit li, input logic [1:0] src, input logic [31:0] imm, input logic [31:0] tmpl,
                       input logic [4:0] rd, output int n, output logic [31:0] w0, output logic [31:0] w1,
                       output logic e0);
    longint v, lo_s, hi_l;
    logic [11:0] lo;
    logic [19:0] hi;
    v = $signed(imm);
    lo = imm[11:0];
    lo_s = longint'($signed(lo));
    w0 = tmpl;
    w1 = 32'd0;
    e0 = 1'b0;
    n = 1;
    if (!li) begin
      case (src)
        2'd0: begin w0[31:20] = imm[11:0]; e0 = !(v >= -2048 && v < 2048); end
        2'd1: begin w0[31:25] = imm[11:5]; w0[11:7] = imm[4:0]; e0 = !(v >= -2048 && v < 2048); end
        2'd2: begin
          w0[31] = imm[12]; w0[30:25] = imm[10:5]; w0[11:8] = imm[4:1]; w0[7] = imm[11];
          e0 = imm[0] || !(v >= -4096 && v < 4096);
        end
        default: begin
          w0[31] = imm[20]; w0[30:21] = imm[10:1]; w0[20] = imm[11]; w0[19:12] = imm[19:12];
          e0 = imm[0] || !(v >= -(64'sd1 << 20) && v < (64'sd1 << 20));
        end
      endcase
    end else begin
      hi_l = (v - lo_s) >>> 12;
      hi = hi_l[19:0];
      if (v >= -2048 && v < 2048) w0 = {lo, 5'd0, 3'd0, rd, 7'b0010011};
      else begin
        w0 = {hi, rd, 7'b0110111};
        if (lo != 12'd0) begin
          n = 2;
          w1 = {lo, rd, 3'd0, rd, 7'b0010011};
        end
      end
    end
  endtask

  task automatic run(input bit li, input logic [1:0] src, input logic [31:0] imm, input logic [31:0] tmpl,
                     input logic [4:0] rd, input int stall);
    int n, s;
    logic [31:0] ew [2];
    logic e0;
    model(li, src, imm, tmpl, rd, n, ew[0], ew[1], e0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_li = li; bus.in_immsrc = src; bus.in_imm = imm;
    bus.in_tmpl = tmpl; bus.in_rd = rd; bus.out_ready = 1'b0;
    #1 chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      s = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      for (int c = 0; c < s; c++) begin
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_word", bus.out_instr, ew[k]);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("word_valid", 32'(bus.out_valid), 32'd1);
      chk("word", bus.out_instr, ew[k]);
      chk("err", 32'(bus.out_err), k == 0 ? 32'(e0) : 32'd0);
      chk("last", 32'(bus.out_last), k == n - 1 ? 32'd1 : 32'd0);
      chk("in_ready_out", 32'(bus.in_ready), k == n - 1 ? 32'd1 : 32'd0);
      if (k == 0) obs0 = bus.out_instr; else obs1 = bus.out_instr;
      @(posedge clk);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1 chk("drained", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] imm;
    bus.in_valid = 1'b0; bus.in_li = 1'b0; bus.in_immsrc = 2'd0; bus.in_imm = '0;
    bus.in_tmpl = '0; bus.in_rd = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    run(1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 5'd0, 0);
    chk("plan_i", obs0, 32'hFFF0_0013);
    run(1'b0, 2'd2, 32'h0000_0FFE, 32'h0000_0063, 5'd0, 0);
    chk("plan_b", obs0, 32'h7E00_0FE3);
    run(1'b0, 2'd2, 32'h0000_1000, 32'h0000_0063, 5'd0, 0);
    run(1'b0, 2'd2, 32'h0000_0003, 32'h0000_0063, 5'd0, 0);
    run(1'b0, 2'd3, 32'h0000_0800, 32'h0000_006F, 5'd0, 0);
    chk("plan_j", obs0, 32'h0010_006F);
    run(1'b0, 2'd3, 32'h0010_0000, 32'h0000_006F, 5'd0, 0);
    run(1'b0, 2'd1, 32'hFFFF_F800, 32'h0123_4523, 5'd0, 1);
    run(1'b0, 2'd1, 32'h0000_0800, 32'h0123_4523, 5'd0, 0);
    run(1'b1, 2'd3, 32'h1234_5FFF, 32'hFFFF_FFFF, 5'd5, 0);
    chk("plan_lui", obs0, 32'h1234_62B7);
    chk("plan_addi", obs1, 32'hFFF2_8293);
    run(1'b1, 2'd0, 32'h0000_07FF, 32'h0, 5'd1, 0);
    chk("plan_li_addi", obs0, 32'h7FF0_0093);
    run(1'b1, 2'd0, 32'h0001_0000, 32'h0, 5'd1, 0);
    chk("plan_li_lui", obs0, 32'h0001_00B7);
    run(1'b1, 2'd0, 32'hFFFF_F800, 32'h0, 5'd2, 0);
    run(1'b1, 2'd0, 32'h8000_0000, 32'h0, 5'd31, 0);
    run(1'b1, 2'd0, 32'h1234_5FFF, 32'h0, 5'd5, 3);
    // reset while the second word of a two-word LI is pending
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_li = 1'b1; bus.in_imm = 32'h1234_5FFF; bus.in_rd = 5'd5; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_instr", bus.out_instr, 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    bus.out_ready = 1'b0;
    #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run(1'b0, 2'd0, 32'h0000_0123, 32'h0000_0013, 5'd0, 0);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        default: imm = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, 12'($urandom)} ^ 32'($urandom_range(0, 1) << 11);
      endcase
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), imm, $urandom, 5'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
